// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: shared states, nibble width and RV32I branch funct3 codes for the serial comparator.
package serial_cmp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int NIB_W = 4;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  function automatic logic f3_signed(input logic [2:0] f3);
    return f3 == F3_BLT || f3 == F3_BGE;
  endfunction
  function automatic logic branch_taken_f(input logic [2:0] f3, input logic lt, input logic eq);
    case (f3)
      F3_BEQ:           return eq;
      F3_BNE:           return !eq;
      F3_BLT, F3_BLTU:  return lt;
      F3_BGE, F3_BGEU:  return !lt;
      default:          return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/comparator_4bit.sv
// comparator_4bit: cascadable nibble comparator; a differing nibble decides, an equal one passes the cascade through.
module comparator_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       in_gt,
  input  logic       in_lt,
  input  logic       in_eq,
  output logic       gt,
  output logic       lt,
  output logic       eq
);
  assign gt = (a > b) | ((a == b) & in_gt);
  assign lt = (a < b) | ((a == b) & in_lt);
  assign eq = (a == b) & in_eq;
endmodule

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: nibble-serial signed/unsigned magnitude compare, LSB nibble first.
// Optional SERIAL_CMP_BRANCH_EN adds funct3 input and branch_taken output for RV32I branches.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SERIAL_CMP_BRANCH_EN
  input  logic [2:0]       funct3,
  output logic             branch_taken,
`endif
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq
);
  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic sgn_q, sgn_d, gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic sgn_in, last, bias, s_gt, s_lt, s_eq;
  logic [NIB_W-1:0] nib_a, nib_b;

`ifdef SERIAL_CMP_BRANCH_EN
  logic [2:0] f3_q, f3_d;
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign sgn_in = f3_signed(funct3);
  assign f3_d = (state_q == IDLE && start_valid) ? funct3 : f3_q;
  assign branch_taken = (state_q == DONE) & branch_taken_f(f3_q, lt_q, eq_q);
  always_ff @(posedge clk or posedge reset)
    if (reset) f3_q <= '0;
    else f3_q <= f3_d;
`else
  assign sgn_in = is_signed;
`endif

  assign last  = count_q == LAST;
  // Flipping the top bit of the MS nibble maps two's-complement order onto unsigned order.
  assign bias  = last & sgn_q;
  assign nib_a = a_q[NIB_W*count_q +: NIB_W] ^ {bias, 3'b000};
  assign nib_b = b_q[NIB_W*count_q +: NIB_W] ^ {bias, 3'b000};

  comparator_4bit u_slice (
    .a(nib_a), .b(nib_b),
    .in_gt(gt_q), .in_lt(lt_q), .in_eq(eq_q),
    .gt(s_gt), .lt(s_lt), .eq(s_eq)
  );

  assign start_ready  = state_q == IDLE;
  assign result_valid = state_q == DONE;
  assign gt = result_valid & gt_q;
  assign lt = result_valid & lt_q;
  assign eq = result_valid & eq_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d = a_q;
    b_d = b_q;
    sgn_d = sgn_q;
    gt_d = gt_q;
    lt_d = lt_q;
    eq_d = eq_q;
    case (state_q)
      IDLE: if (start_valid) begin
        state_d = RUN;
        a_d = a;
        b_d = b;
        sgn_d = sgn_in;
        {gt_d, lt_d, eq_d} = 3'b001;
        count_d = '0;
      end
      RUN: begin
        {gt_d, lt_d, eq_d} = {s_gt, s_lt, s_eq};
        count_d = last ? '0 : count_q + CW'(1);
        state_d = last ? DONE : RUN;
      end
      DONE: state_d = result_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sgn_q <= 1'b0;
      gt_q <= 1'b0;
      lt_q <= 1'b0;
      eq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q <= a_d;
      b_q <= b_d;
      sgn_q <= sgn_d;
      gt_q <= gt_d;
      lt_q <= lt_d;
      eq_q <= eq_d;
    end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: directed scoreboard bench for the nibble-serial comparator.
module tb_serial_magnitude_comparator;
  logic clk = 1'b0, reset = 1'b1;
  logic start_valid = 1'b0, is_signed = 1'b0, result_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic start_ready, result_valid, gt, lt, eq;
  int checks = 0, passed = 0;

  typedef struct packed {logic [2:0] res; logic taken;} exp_t;
  exp_t sb[$];

`ifdef SERIAL_CMP_BRANCH_EN
  logic [2:0] funct3 = '0;
  logic branch_taken;
`endif

  serial_magnitude_comparator #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
`ifdef SERIAL_CMP_BRANCH_EN
    .funct3(funct3), .branch_taken(branch_taken),
`endif
    .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .is_signed(is_signed),
    .result_valid(result_valid), .result_ready(result_ready),
    .gt(gt), .lt(lt), .eq(eq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    if (s) return ($signed(x) > $signed(y)) ? 3'b100 : ($signed(x) < $signed(y)) ? 3'b010 : 3'b001;
    return (x > y) ? 3'b100 : (x < y) ? 3'b010 : 3'b001;
  endfunction

  function automatic logic taken_model(input logic [2:0] f, input logic [2:0] r);
    case (f)
      3'b000: return r[0];
      3'b001: return !r[0];
      3'b100, 3'b110: return r[1];
      3'b101, 3'b111: return !r[1];
      default: return 1'b0;
    endcase
  endfunction

  task automatic compare(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input logic [2:0] f, input int hold);
    int n;
    exp_t e;
    logic [2:0] snap;
    logic sgn;
`ifdef SERIAL_CMP_BRANCH_EN
    sgn = (f == 3'b100 || f == 3'b101);
    funct3 = f;
`else
    sgn = s;
`endif
    @(negedge clk);
    a = x; b = y; is_signed = s; start_valid = 1'b1;
    chk("start_ready_idle", 32'(start_ready), 32'd1);
    e.res = model(x, y, sgn);
    e.taken = taken_model(f, e.res);
    sb.push_back(e);
    @(posedge clk); #1;
    start_valid = 1'b0; a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
    n = 0;
    while (!result_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), 32'd8);
    e = sb.pop_front();
    snap = {gt, lt, eq};
    chk("gt_lt_eq", 32'(snap), 32'(e.res));
`ifdef SERIAL_CMP_BRANCH_EN
    chk("branch_taken", 32'(branch_taken), 32'(e.taken));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start_valid = i[0];
      chk("hold_valid", 32'(result_valid), 32'd1);
      chk("hold_result", 32'({gt, lt, eq}), 32'(snap));
      chk("hold_no_start", 32'(start_ready), 32'd0);
    end
    @(negedge clk);
    start_valid = 1'b0; result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("valid_drop", 32'(result_valid), 32'd0);
    chk("ready_back", 32'(start_ready), 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_outputs", 32'({gt, lt, eq}), 32'd0);
    @(negedge clk); reset = 1'b0;
    #1 chk("rst_start_ready", 32'(start_ready), 32'd1);
    compare(32'h12345678, 32'h12345678, 1'b0, 3'b110, 0);
    compare(32'hA0000000, 32'h0FFFFFFF, 1'b0, 3'b110, 0);
    compare(32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b100, 0);
    compare(32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b110, 0);
    compare(32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b100, 0);
    compare(32'h00000010, 32'h0000000F, 1'b0, 3'b110, 5);
    // Abort mid-RUN: outputs must clear immediately and the next compare must be clean.
    @(negedge clk);
    a = 32'h00000005; b = 32'h00000003; is_signed = 1'b0; start_valid = 1'b1;
`ifdef SERIAL_CMP_BRANCH_EN
    funct3 = 3'b110;
`endif
    @(posedge clk); #1 start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_valid", 32'(result_valid), 32'd0);
    chk("abort_outputs", 32'({gt, lt, eq}), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", 32'(start_ready), 32'd1);
    compare(32'h00000003, 32'h00000005, 1'b0, 3'b110, 0);
    for (int i = 0; i < 4; i++)
      compare($urandom, $urandom, i[0], i[0] ? 3'b100 : 3'b110, 1);
`ifdef SERIAL_CMP_BRANCH_EN
    compare(32'hFFFFFFFB, 32'hFFFFFFFB, 1'b0, 3'b101, 0);
    compare(32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b110, 0);
    compare(32'h00000001, 32'h00000002, 1'b0, 3'b010, 0);
    compare(32'h00000007, 32'h00000007, 1'b0, 3'b000, 0);
    compare(32'h00000007, 32'h00000007, 1'b0, 3'b001, 0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
